handshake_mul_fixed: RTL and testbench

//  Pipelined signed fixed-point multiplier with elastic handshake, directly downstream of the coefficient

---
 rtl/faust_fixed_pkg.sv | 23 ++
 rtl/handshake_pipe_ctrl.sv | 37 +++
 rtl/handshake_mul_fixed.sv | 119 +++++++++++
 tb/tb_handshake_mul_fixed.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/faust_fixed_pkg.sv
// rtl/faust_fixed_pkg.sv - shared fixed-point constants and helpers for the soft-clip datapath
package faust_fixed_pkg;

    localparam int FRAC_BITS_DEFAULT = 23;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // Half an output LSB, added before the arithmetic shift (round half up).
    function automatic logic signed [127:0] round_const(input int f);
        return 128'sd1 <<< (f - 1);
    endfunction

    function automatic logic signed [127:0] sat_max(input int w);
        return (128'sd1 <<< (w - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [127:0] sat_min(input int w);
        return -(128'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/handshake_pipe_ctrl.sv
// rtl/handshake_pipe_ctrl.sv - valid shift register, stall-all enable and two-input join
module handshake_pipe_ctrl #(
    parameter int LATENCY = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic lhs_valid,
    input  logic rhs_valid,
    input  logic outs_ready,
    output logic lhs_ready,
    output logic rhs_ready,
    output logic ce,
    output logic outs_valid
);

    logic [LATENCY-1:0] r_vld;
    logic               w_fire;

    assign ce         = ~r_vld[LATENCY-1] | outs_ready;
    assign w_fire     = lhs_valid & rhs_valid & ce;
    // Each ready looks only at the partner's valid, so no loop through its own valid.
    assign lhs_ready  = rhs_valid & ce;
    assign rhs_ready  = lhs_valid & ce;
    assign outs_valid = r_vld[LATENCY-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
        end else if (ce) begin
            r_vld[0] <= w_fire;
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

endmodule

// File: rtl/handshake_mul_fixed.sv
// rtl/handshake_mul_fixed.sv - pipelined signed Q-format multiplier with join handshake
// Define MUL_SAT_EN to clamp out-of-range results instead of wrapping.
module handshake_mul_fixed
    import faust_fixed_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FRAC_BITS  = FRAC_BITS_DEFAULT,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lhs,
    input  logic                  lhs_valid,
    output logic                  lhs_ready,
    input  logic [DATA_WIDTH-1:0] rhs,
    input  logic                  rhs_valid,
    output logic                  rhs_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = prod_width(DATA_WIDTH);
    localparam logic signed [PW-1:0] C_ROUND   = PW'(round_const(FRAC_BITS));
    localparam logic signed [PW-1:0] C_SAT_MAX = PW'(sat_max(DATA_WIDTH));
    localparam logic signed [PW-1:0] C_SAT_MIN = PW'(sat_min(DATA_WIDTH));

    logic         w_ce;
    logic [W-1:0] r_q;

    function automatic logic [W-1:0] f_round_narrow(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] r;
        logic signed [PW-1:0] q;
        r = p + C_ROUND;
        q = r >>> FRAC_BITS;
`ifdef MUL_SAT_EN
        if (q > C_SAT_MAX) begin
            q = C_SAT_MAX;
        end else if (q < C_SAT_MIN) begin
            q = C_SAT_MIN;
        end
`endif
        return W'(q);
    endfunction

    handshake_pipe_ctrl #(.LATENCY(LATENCY)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .lhs_valid  (lhs_valid),
        .rhs_valid  (rhs_valid),
        .outs_ready (outs_ready),
        .lhs_ready  (lhs_ready),
        .rhs_ready  (rhs_ready),
        .ce         (w_ce),
        .outs_valid (outs_valid)
    );

    generate
        if (LATENCY == 1) begin : gen_l1
            logic signed [PW-1:0] w_prod;
            assign w_prod = PW'($signed(lhs)) * PW'($signed(rhs));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else if (w_ce) begin
                    r_q <= f_round_narrow(w_prod);
                end
            end
        end else if (LATENCY == 2) begin : gen_l2
            logic [W-1:0]         r_a;
            logic [W-1:0]         r_b;
            logic signed [PW-1:0] w_prod;
            assign w_prod = PW'($signed(r_a)) * PW'($signed(r_b));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_q <= '0;
                end else if (w_ce) begin
                    r_a <= lhs;
                    r_b <= rhs;
                    r_q <= f_round_narrow(w_prod);
                end
            end
        end else begin : gen_ln
            logic [W-1:0]         r_a;
            logic [W-1:0]         r_b;
            logic signed [PW-1:0] w_prod;
            // r_p[0] is the registered product; later entries only add delay.
            logic signed [PW-1:0] r_p [LATENCY-2];
            assign w_prod = PW'($signed(r_a)) * PW'($signed(r_b));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_a <= '0;
                    r_b <= '0;
                    r_q <= '0;
                    for (int i = 0; i < LATENCY - 2; i++) begin
                        r_p[i] <= '0;
                    end
                end else if (w_ce) begin
                    r_a    <= lhs;
                    r_b    <= rhs;
                    r_p[0] <= w_prod;
                    for (int i = 1; i < LATENCY - 2; i++) begin
                        r_p[i] <= r_p[i-1];
                    end
                    r_q <= f_round_narrow(r_p[LATENCY-3]);
                end
            end
        end
    endgenerate

    assign outs = r_q;

endmodule

// File: tb/tb_handshake_mul_fixed.sv
// tb/tb_handshake_mul_fixed.sv - directed self-checking bench for handshake_mul_fixed
module tb_handshake_mul_fixed;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] lhs;
    logic        lhs_valid;
    logic        lhs_ready;
    logic [23:0] rhs;
    logic        rhs_valid;
    logic        rhs_ready;
    logic [23:0] outs;
    logic        outs_valid;
    logic        outs_ready;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    handshake_mul_fixed #(
        .DATA_WIDTH (24),
        .FRAC_BITS  (23),
        .LATENCY    (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lhs        (lhs),
        .lhs_valid  (lhs_valid),
        .lhs_ready  (lhs_ready),
        .rhs        (rhs),
        .rhs_valid  (rhs_valid),
        .rhs_ready  (rhs_ready),
        .outs       (outs),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated token: outs_valid must rise exactly three cycles after the handshake cycle.
    task automatic issue_one(input logic [23:0] a, input logic [23:0] b,
                             input logic [23:0] exp, input string tag);
        lhs        = a;
        rhs        = b;
        lhs_valid  = 1'b1;
        rhs_valid  = 1'b1;
        outs_ready = 1'b1;
        #1;
        chk({tag, "_lhs_ready"}, lhs_ready, 1);
        chk({tag, "_rhs_ready"}, rhs_ready, 1);
        step();
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        #1;
        chk({tag, "_lat1"}, outs_valid, 0);
        step();
        chk({tag, "_lat2"}, outs_valid, 0);
        step();
        chk({tag, "_valid"}, outs_valid, 1);
        chk({tag, "_data"}, outs, exp);
        step();
        chk({tag, "_drain"}, outs_valid, 0);
    endtask

    initial begin
        int          sent;
        int          got;
        int          cyc;
        logic        was_stall;
        logic [23:0] held;
        logic [23:0] recv [10];
        logic [23:0] exp_sat;

        rst        = 1'b0;
        lhs        = '0;
        rhs        = '0;
        lhs_valid  = 1'b0;
        rhs_valid  = 1'b0;
        outs_ready = 1'b0;
        step();
        step();
        chk("reset_valid", outs_valid, 0);
        chk("reset_data", outs, 24'h000000);
        rst = 1'b1;
        step();

`ifdef MUL_SAT_EN
        exp_sat = 24'h7FFFFF;
`else
        exp_sat = 24'h800000;
`endif
        issue_one(24'h400000, 24'hFD652C, 24'hFEB296, "half_x_neg");
        issue_one(24'h800000, 24'h800000, exp_sat,    "neg1_sq");
        issue_one(24'h000001, 24'h400000, 24'h000001, "round_up");
        issue_one(24'hFFFFFF, 24'h400000, 24'h000000, "round_neg");
        issue_one(24'h400000, 24'h400000, 24'h200000, "quarter");
        issue_one(24'hC00000, 24'h400000, 24'hE00000, "neg_quarter");

        // Join: a lone lhs token must wait for its partner.
        lhs        = 24'h400000;
        rhs        = 24'h400000;
        lhs_valid  = 1'b1;
        rhs_valid  = 1'b0;
        outs_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("join_wait_lready", lhs_ready, 0);
            chk("join_wait_ovalid", outs_valid, 0);
            step();
        end
        rhs_valid = 1'b1;
        #1;
        chk("join_lhs_ready", lhs_ready, 1);
        chk("join_rhs_ready", rhs_ready, 1);
        step();
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        #1;
        chk("join_lat1", outs_valid, 0);
        step();
        chk("join_lat2", outs_valid, 0);
        step();
        chk("join_valid", outs_valid, 1);
        chk("join_data", outs, 24'h200000);
        step();
        chk("join_drain", outs_valid, 0);

        // Back-pressure: token k is 0.5 * 2(k+1) LSB, so it comes out as k+1.
        sent      = 0;
        got       = 0;
        cyc       = 0;
        was_stall = 1'b0;
        held      = '0;
        lhs       = 24'h400000;
        while (got < 10 && cyc < 60) begin
            lhs_valid  = (sent < 10);
            rhs_valid  = (sent < 10);
            rhs        = 24'(2 * (sent + 1));
            outs_ready = !(cyc >= 4 && cyc <= 9);
            #1;
            if (cyc >= 4 && cyc <= 9) begin
                chk("bp_ready_low", lhs_ready, 0);
            end
            if (was_stall) begin
                chk("bp_hold_valid", outs_valid, 1);
                chk("bp_hold_data", outs, held);
            end
            was_stall = outs_valid & ~outs_ready;
            held      = outs;
            if (outs_valid && outs_ready) begin
                if (got < 10) begin
                    recv[got] = outs;
                end
                got++;
            end
            if (lhs_valid && lhs_ready) begin
                sent++;
            end
            step();
            cyc++;
        end
        lhs_valid  = 1'b0;
        rhs_valid  = 1'b0;
        outs_ready = 1'b1;
        chk("bp_count", got, 10);
        for (int k = 0; k < 10; k++) begin
            chk("bp_order", recv[k], 24'(k + 1));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_no_extra", outs_valid, 0);
        end

        // Reset with three tokens in flight.
        lhs        = 24'h400000;
        lhs_valid  = 1'b1;
        rhs_valid  = 1'b1;
        outs_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rhs = 24'(2 * (i + 1));
            step();
        end
        chk("rst_pre_valid", outs_valid, 1);
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        rst       = 1'b0;
        #1;
        chk("rst_async_valid", outs_valid, 0);
        chk("rst_async_data", outs, 24'h000000);
        step();
        rst       = 1'b1;
        rhs_valid = 1'b1;
        #1;
        chk("rst_release_ready", lhs_ready, 1);
        rhs_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rst_no_stale", outs_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
